// File: rtl/gates_pkg.sv
// rtl/gates_pkg.sv - shared constants for the registered AND/NAND/NOR gate bank
package gates_pkg;

    localparam int GATES_WIDTH = 1;

    // Result registers clear to zero, even for nand/nor whose logical value at a=b=0 is 1.
    localparam logic GATES_RST_BIT = 1'b0;

    // Per-bit truth table indexed by {a,b}; each 3-bit entry is {and,nand,nor}.
    localparam logic [11:0] GATES_TRUTH = 12'b100_010_010_011;

endpackage

// File: rtl/gate_bit_slice.sv
// rtl/gate_bit_slice.sv - one-bit combinational and/nand/nor slice
module gate_bit_slice (
    input  logic a,
    input  logic b,
    output logic and_y,
    output logic nand_y,
    output logic nor_y
);

    assign and_y  = a & b;
    assign nand_y = ~(a & b);
    assign nor_y  = ~(a | b);

endmodule

// File: rtl/and_nand_nor_gates.sv
// rtl/and_nand_nor_gates.sv - one-cycle registered gate bank with valid and all-ones flags
// GATES_HOLD_EN: results hold unless in_valid; otherwise they capture a,b on every edge.
module and_nand_nor_gates
    import gates_pkg::*;
#(
    parameter int WIDTH = GATES_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] and_y,
    output logic [WIDTH-1:0] nand_y,
    output logic [WIDTH-1:0] nor_y,
    output logic             and_all,
    output logic             nand_all,
    output logic             nor_all,
    output logic             out_valid
);

    logic [WIDTH-1:0] and_c;
    logic [WIDTH-1:0] nand_c;
    logic [WIDTH-1:0] nor_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        gate_bit_slice u_slice (
            .a      (a[i]),
            .b      (b[i]),
            .and_y  (and_c[i]),
            .nand_y (nand_c[i]),
            .nor_y  (nor_c[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            and_y     <= {WIDTH{GATES_RST_BIT}};
            nand_y    <= {WIDTH{GATES_RST_BIT}};
            nor_y     <= {WIDTH{GATES_RST_BIT}};
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
`ifdef GATES_HOLD_EN
            // Gating the capture keeps X on idle operands out of the result registers.
            if (in_valid) begin
                and_y  <= and_c;
                nand_y <= nand_c;
                nor_y  <= nor_c;
            end
`else
            and_y  <= and_c;
            nand_y <= nand_c;
            nor_y  <= nor_c;
`endif
        end
    end

    assign and_all  = &and_y;
    assign nand_all = &nand_y;
    assign nor_all  = &nor_y;

endmodule

// File: tb/tb_and_nand_nor_gates.sv
// tb/tb_and_nand_nor_gates.sv - self-checking bench for and_nand_nor_gates (WIDTH=4 and WIDTH=1)
module tb_and_nand_nor_gates;
    import gates_pkg::*;

    typedef struct {
        logic [3:0] and_v;
        logic [3:0] nand_v;
        logic [3:0] nor_v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a4, b4;
    logic       vin;
    logic [3:0] and4, nand4, nor4;
    logic       and_all4, nand_all4, nor_all4, out_valid4;
    logic [0:0] and1, nand1, nor1;
    logic       and_all1, nand_all1, nor_all1, out_valid1;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t held;

    always #5 clk = ~clk;

    and_nand_nor_gates #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(vin),
        .and_y(and4), .nand_y(nand4), .nor_y(nor4),
        .and_all(and_all4), .nand_all(nand_all4), .nor_all(nor_all4),
        .out_valid(out_valid4)
    );

    and_nand_nor_gates #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a4[0:0]), .b(b4[0:0]), .in_valid(vin),
        .and_y(and1), .nand_y(nand1), .nor_y(nor1),
        .and_all(and_all1), .nand_all(nand_all1), .nor_all(nor_all1),
        .out_valid(out_valid1)
    );

    function automatic exp_t model(input logic [3:0] av, input logic [3:0] bv);
        exp_t       e;
        logic [11:0] tt;
        logic [2:0]  ent;
        int          idx;
        tt = GATES_TRUTH;
        for (int i = 0; i < 4; i++) begin
            idx = {30'd0, av[i], bv[i]};
            ent = tt[3*idx +: 3];
            e.and_v[i]  = ent[2];
            e.nand_v[i] = ent[1];
            e.nor_v[i]  = ent[0];
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic vv);
        check("out_valid4", {3'b0, out_valid4}, {3'b0, vv});
        check("out_valid1", {3'b0, out_valid1}, {3'b0, vv});
        check("and_y4",  and4,  held.and_v);
        check("nand_y4", nand4, held.nand_v);
        check("nor_y4",  nor4,  held.nor_v);
        check("and_all4",  {3'b0, and_all4},  {3'b0, held.and_v == 4'hF});
        check("nand_all4", {3'b0, nand_all4}, {3'b0, held.nand_v == 4'hF});
        check("nor_all4",  {3'b0, nor_all4},  {3'b0, held.nor_v == 4'hF});
        check("and_y1",  {3'b0, and1},  {3'b0, held.and_v[0]});
        check("nand_y1", {3'b0, nand1}, {3'b0, held.nand_v[0]});
        check("nor_y1",  {3'b0, nor1},  {3'b0, held.nor_v[0]});
        check("flags1", {1'b0, and_all1, nand_all1, nor_all1},
              {1'b0, held.and_v[0], held.nand_v[0], held.nor_v[0]});
        if (out_valid4 === 1'b1) begin
            check("inv_nand_not_and", nand4, ~and4);
            check("inv_nor_and_zero", nor4 & and4, 4'h0);
        end
    endtask

    task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic vv);
        exp_t e;
        a4  = av;
        b4  = bv;
        vin = vv;
        e = model(av, bv);
        if (vv) sb.push_back(e);
        @(posedge clk);
        #1;
        if (vv) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL scoreboard_empty observed=0 expected=1");
            end
            if (sb.size() > 0) held = sb.pop_front();
        end else begin
`ifndef GATES_HOLD_EN
            held = e;
`endif
        end
        check_outputs(vv);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_and4"},  and4,  4'h0);
        check({tag, "_nand4"}, nand4, 4'h0);
        check({tag, "_nor4"},  nor4,  4'h0);
        check({tag, "_flags4"}, {out_valid4, and_all4, nand_all4, nor_all4}, 4'h0);
        check({tag, "_dut1"}, {and1, nand1, nor1, out_valid1}, 4'h0);
        check({tag, "_flags1"}, {1'b0, and_all1, nand_all1, nor_all1}, 4'h0);
    endtask

    task automatic clear_model();
        sb.delete();
        held.and_v  = 4'h0;
        held.nand_v = 4'h0;
        held.nor_v  = 4'h0;
    endtask

    initial begin
        rst = 1'b1;
        a4  = 4'h0;
        b4  = 4'h0;
        vin = 1'b0;
        clear_model();
        #12;
        check_all_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Truth table on bit 0 (WIDTH=1 instance follows bit 0 of WIDTH=4)
        step(4'b0000, 4'b0000, 1'b1);
        check("tt00", {1'b0, and1, nand1, nor1}, 4'b0011);
        step(4'b0000, 4'b0001, 1'b1);
        check("tt01", {1'b0, and1, nand1, nor1}, 4'b0010);
        step(4'b0001, 4'b0000, 1'b1);
        check("tt10", {1'b0, and1, nand1, nor1}, 4'b0010);
        step(4'b0001, 4'b0001, 1'b1);
        check("tt11", {1'b0, and1, nand1, nor1}, 4'b0100);

        step(4'b1100, 4'b1010, 1'b1);
        check("mix_and",  and4,  4'b1000);
        check("mix_nand", nand4, 4'b0111);
        check("mix_nor",  nor4,  4'b0001);
        check("mix_flags", {1'b0, and_all4, nand_all4, nor_all4}, 4'b0000);

        step(4'hF, 4'hF, 1'b1);
        check("ones_and_all", {3'b0, and_all4}, 4'b0001);
        step(4'h0, 4'h0, 1'b1);
        check("zeros_flags", {1'b0, and_all4, nand_all4, nor_all4}, 4'b0011);

        step(4'b0110, 4'b0011, 1'b1);
        step(4'b1001, 4'b1111, 1'b0);
        step(4'b0101, 4'b0000, 1'b0);
`ifdef GATES_HOLD_EN
        check("hold_and", and4, 4'b0010);
        step(4'bxxxx, 4'bxxxx, 1'b0);
        check("hold_x_nand", nand4, 4'b1101);
`else
        check("follow_nor", nor4, 4'b1010);
`endif

        // Asynchronous reset mid-cycle with a beat pending
        step(4'hF, 4'hF, 1'b1);
        vin = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        clear_model();
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        @(negedge clk);
        rst = 1'b0;
        vin = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            step(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
